topsub: RTL and testbench

Bit-serial four-operand subtractor computing q = a - b - c - d (mod 2^WIDTH), the subtraction counterpart of the bit-serial adder tree `topadd`. Operands are captured on a start handshake, shifted LSB-first through three cascaded serial full-subtractors with registered borrows, and the result is reassembled into a parallel word. It uses the same bit-serial datapath scheme as `topadd` and exposes a start/busy/done handshake, so a controller can issue back-to-back operations.

---
 rtl/topsub.sv | 129 ++++++++++++
 tb/tb_topsub.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/topsub.sv
// topsub: bit-serial four-operand subtractor, q = a - b - c - d (mod 2^WIDTH).
// Operands shift LSB-first through three cascaded serial full-subtractors,
// each with a registered borrow; one bit is processed per clock.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   S_IDLE  | waiting for start; q/neg hold the last result
//   S_SHIFT | processing one operand bit per clock
module topsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             neg,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, c_sh_q, d_sh_q;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] q_q;
  logic             neg_q, done_q;
  logic             br1_q, br2_q, br3_q;
  logic             br1_d, br2_d, br3_d;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] cnt_q;
  logic             last_bit;

  assign last_bit = (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state: leave IDLE on start, return once the last bit has been processed
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)    state_d = S_SHIFT;
      S_SHIFT: if (last_bit) state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // Outputs: busy decoded from state, result and flags straight from registers
  always_comb begin
    busy = (state_q == S_SHIFT);
    done = done_q;
    q    = q_q;
    neg  = neg_q;
  end

  // Serial subtractor chain on the current LSBs; borrow out when subtrahend+borrow > minuend
  always_comb begin
    s1    = a_sh_q[0] ^ b_sh_q[0] ^ br1_q;
    br1_d = (~a_sh_q[0] & (b_sh_q[0] | br1_q)) | (b_sh_q[0] & br1_q);
    s2    = s1 ^ c_sh_q[0] ^ br2_q;
    br2_d = (~s1 & (c_sh_q[0] | br2_q)) | (c_sh_q[0] & br2_q);
    s3    = s2 ^ d_sh_q[0] ^ br3_q;
    br3_d = (~s2 & (d_sh_q[0] | br3_q)) | (d_sh_q[0] & br3_q);
    res_d = {s3, res_q[WIDTH-1:1]};
  end

  // Datapath: capture on start, shift while busy, publish result on the last bit
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      c_sh_q <= '0;
      d_sh_q <= '0;
      res_q  <= '0;
      q_q    <= '0;
      neg_q  <= 1'b0;
      done_q <= 1'b0;
      br1_q  <= 1'b0;
      br2_q  <= 1'b0;
      br3_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q == S_IDLE) begin
        if (start) begin
          a_sh_q <= a;
          b_sh_q <= b;
          c_sh_q <= c;
          d_sh_q <= d;
          br1_q  <= 1'b0;
          br2_q  <= 1'b0;
          br3_q  <= 1'b0;
          cnt_q  <= '0;
        end
      end else begin
        a_sh_q <= a_sh_q >> 1;
        b_sh_q <= b_sh_q >> 1;
        c_sh_q <= c_sh_q >> 1;
        d_sh_q <= d_sh_q >> 1;
        br1_q  <= br1_d;
        br2_q  <= br2_d;
        br3_q  <= br3_d;
        res_q  <= res_d;
        cnt_q  <= cnt_q + CNT_W'(1);
        if (last_bit) begin
          // true value is q - 2^WIDTH * (number of final borrows), so any borrow means negative
          q_q    <= res_d;
          neg_q  <= br1_d | br2_d | br3_d;
          done_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_topsub.sv
// tb_topsub: vector table plus handshake/reset sequences for topsub,
// with a queue of expected results checked whenever done pulses.
module tb_topsub;

  localparam int WIDTH = 8;
  localparam int NVEC  = 10;

  logic             clk = 1'b0;
  logic             rst, start;
  logic [WIDTH-1:0] a, b, c, d, q;
  logic             neg, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] a, b, c, d;
    logic [7:0] q;
    logic       neg;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic       neg;
    int         cyc;
  } exp_t;

  vec_t vecs[NVEC];
  exp_t sb[$];
  exp_t mon_e;

  topsub #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .c    (c),
    .d    (d),
    .q    (q),
    .neg  (neg),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t model(input logic [7:0] va, vb, vc, vd);
    vec_t v;
    int   full;
    full  = int'(va) - int'(vb) - int'(vc) - int'(vd);
    v.a   = va;
    v.b   = vb;
    v.c   = vc;
    v.d   = vd;
    v.q   = full[7:0];
    v.neg = (full < 0);
    return v;
  endfunction

  // Monitor: every done pulse must match the oldest expected result, on time
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (done === 1'b1) begin
      chk("done_busy_exclusive", {31'd0, busy}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 with q=%0d, expected no done (cycle %0d)", q, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("result_q",   {24'd0, q},   {24'd0, mon_e.q});
        chk("result_neg", {31'd0, neg}, {31'd0, mon_e.neg});
        chk("done_cycle", cyc,          mon_e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drive an operation that must be accepted at the next edge; queue its expectation
  task automatic issue(input vec_t v);
    exp_t e;
    a = v.a; b = v.b; c = v.c; d = v.d;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("accept_busy", {31'd0, busy}, 32'd1);
    e.q   = v.q;
    e.neg = v.neg;
    e.cyc = cyc + WIDTH;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3 * WIDTH && sb.size() != 0; k++) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL wait_done_timeout: got %0d results pending, expected 0 (cycle %0d)", sb.size(), cyc);
      sb.delete();
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0;
    a = '0; b = '0; c = '0; d = '0;

    vecs[0] = '{a: 8'd10,  b: 8'd2,   c: 8'd3,   d: 8'd4,   q: 8'd1,   neg: 1'b0};
    vecs[1] = '{a: 8'd1,   b: 8'd2,   c: 8'd3,   d: 8'd4,   q: 8'd248, neg: 1'b1};
    vecs[2] = '{a: 8'd255, b: 8'd0,   c: 8'd0,   d: 8'd0,   q: 8'd255, neg: 1'b0};
    vecs[3] = '{a: 8'd0,   b: 8'd255, c: 8'd255, d: 8'd255, q: 8'd3,   neg: 1'b1};
    vecs[4] = '{a: 8'd0,   b: 8'd0,   c: 8'd0,   d: 8'd0,   q: 8'd0,   neg: 1'b0};
    vecs[5] = '{a: 8'd200, b: 8'd1,   c: 8'd1,   d: 8'd1,   q: 8'd197, neg: 1'b0};
    vecs[6] = '{a: 8'd128, b: 8'd64,  c: 8'd32,  d: 8'd16,  q: 8'd16,  neg: 1'b0};
    vecs[7] = '{a: 8'd0,   b: 8'd0,   c: 8'd0,   d: 8'd1,   q: 8'd255, neg: 1'b1};
    vecs[8] = model(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    vecs[9] = model(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_q",    {24'd0, q},    32'd0);
    chk("reset_neg",  {31'd0, neg},  32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    tick();

    // Basic op: busy for WIDTH cycles, q untouched until done
    issue(vecs[0]);
    for (int i = 0; i < WIDTH; i++) begin
      chk("basic_busy",    {31'd0, busy}, 32'd1);
      chk("basic_no_done", {31'd0, done}, 32'd0);
      chk("basic_q_hold",  {24'd0, q},    32'd0);
      tick();
    end
    chk("basic_done", {31'd0, done}, 32'd1);
    chk("basic_idle", {31'd0, busy}, 32'd0);
    tick();
    chk("basic_done_drop", {31'd0, done}, 32'd0);
    chk("basic_q_kept",    {24'd0, q},    32'd1);

    // Table, back-to-back: each next start is issued during the previous done cycle
    for (int i = 1; i < NVEC; i++) begin
      issue(vecs[i]);
      repeat (WIDTH) tick();
      chk("b2b_done_cycle", {31'd0, done}, 32'd1);
    end
    wait_idle();

    // Start while busy is ignored; then start in the done cycle is accepted
    issue(vecs[0]);
    tick();
    tick();
    a = 8'd200; b = 8'd1; c = 8'd1; d = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ignored_start_busy", {31'd0, busy}, 32'd1);
    repeat (WIDTH - 3) tick();
    chk("robust_done", {31'd0, done}, 32'd1);
    issue(vecs[5]);
    repeat (WIDTH) tick();
    chk("robust_done2", {31'd0, done}, 32'd1);
    wait_idle();

    // Reset at bit 4 aborts the operation
    issue(vecs[0]);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("abort_q",    {24'd0, q},    32'd0);
    chk("abort_neg",  {31'd0, neg},  32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    sb.delete();
    rst = 1'b0;
    repeat (2 * WIDTH) tick();
    issue(vecs[1]);
    wait_idle();
    chk("restart_q",   {24'd0, q},   32'd248);
    chk("restart_neg", {31'd0, neg}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
